// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver feeding a first-word-fall-through receive FIFO.
// Default frame is 8N1; define RX_PARITY_EN for 8E1 with parity checking.
module uart_rx #(
   parameter int F_sys      = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_in,
   input  logic [3:0] baud_rate,
   input  logic       CPU_read,
   output logic [7:0] data_out,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       BCLK_RX,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       parity_err
);
   localparam int DIV_MAX = F_sys / (16 * 1200);
   localparam int CNT_W   = $clog2(DIV_MAX + 1);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   function automatic logic [CNT_W-1:0] f_div(input logic [3:0] sel);
      int baud;
      case (sel)
         4'd0:    baud = 1200;
         4'd1:    baud = 2400;
         4'd2:    baud = 4800;
         4'd3:    baud = 9600;
         4'd4:    baud = 19200;
         4'd5:    baud = 38400;
         4'd6:    baud = 57600;
         4'd7:    baud = 115200;
         default: baud = 9600;
      endcase
      return CNT_W'(F_sys / (16 * baud));
   endfunction

   logic             r_rx_meta, r_rx_sync;
   logic [3:0]       r_baud_q;
   logic [CNT_W-1:0] r_div_cnt;
   logic [CNT_W-1:0] w_div;
   logic             r_tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx_in;
         r_rx_sync <= r_rx_meta;
      end
   end

   // Oversampling tick; any change of baud select restarts the divider from zero.
   assign w_div = f_div(baud_rate);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baud_q  <= '0;
         r_div_cnt <= '0;
         r_tick    <= 1'b0;
      end else begin
         r_baud_q <= baud_rate;
         if (baud_rate != r_baud_q) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
         end else if (r_div_cnt == w_div - 1'b1) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_tick    <= 1'b0;
         end
      end
   end

   assign BCLK_RX = r_tick;

   state_t     r_state, w_state_n;
   logic [3:0] r_os_cnt, w_os_cnt_n;
   logic [2:0] r_bit_idx, w_bit_idx_n;
   logic       r_hold, w_hold_n;
   logic       r_push, w_push_n;
   logic       r_ferr, w_ferr_n;
   logic       w_shift_en;
   logic [7:0] r_shift;
`ifdef RX_PARITY_EN
   logic       r_par_bad, w_par_bad_n;
   logic       r_perr, w_perr_n;
`endif

   always_comb begin
      w_state_n   = r_state;
      w_os_cnt_n  = r_os_cnt;
      w_bit_idx_n = r_bit_idx;
      w_hold_n    = r_hold;
      w_push_n    = 1'b0;
      w_ferr_n    = 1'b0;
      w_shift_en  = 1'b0;
`ifdef RX_PARITY_EN
      w_par_bad_n = r_par_bad;
      w_perr_n    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // After a framing error, wait for the line to return high before hunting again.
            if (r_hold) begin
               if (r_rx_sync) w_hold_n = 1'b0;
            end else if (r_tick && !r_rx_sync) begin
               w_state_n  = START;
               w_os_cnt_n = '0;
            end
         end
         START: if (r_tick) begin
            if (r_os_cnt == 4'd7) begin
               w_os_cnt_n  = '0;
               w_bit_idx_n = '0;
               w_state_n   = r_rx_sync ? IDLE : DATA;
            end else begin
               w_os_cnt_n = r_os_cnt + 1'b1;
            end
         end
         DATA: if (r_tick) begin
            if (r_os_cnt == 4'd15) begin
               w_os_cnt_n  = '0;
               w_shift_en  = 1'b1;
               w_bit_idx_n = r_bit_idx + 1'b1;
`ifdef RX_PARITY_EN
               if (r_bit_idx == 3'd7) w_state_n = PARITY;
`else
               if (r_bit_idx == 3'd7) w_state_n = STOP;
`endif
            end else begin
               w_os_cnt_n = r_os_cnt + 1'b1;
            end
         end
         PARITY: begin
`ifdef RX_PARITY_EN
            if (r_tick) begin
               if (r_os_cnt == 4'd15) begin
                  w_os_cnt_n  = '0;
                  w_par_bad_n = r_rx_sync ^ (^r_shift);
                  w_state_n   = STOP;
               end else begin
                  w_os_cnt_n = r_os_cnt + 1'b1;
               end
            end
`else
            w_state_n = IDLE;
`endif
         end
         STOP: if (r_tick) begin
            if (r_os_cnt == 4'd15) begin
               w_os_cnt_n = '0;
               w_state_n  = IDLE;
               if (!r_rx_sync) begin
                  w_ferr_n = 1'b1;
                  w_hold_n = 1'b1;
               end
`ifdef RX_PARITY_EN
               else if (r_par_bad) w_perr_n = 1'b1;
`endif
               else w_push_n = 1'b1;
            end else begin
               w_os_cnt_n = r_os_cnt + 1'b1;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_os_cnt  <= '0;
         r_bit_idx <= '0;
         r_hold    <= 1'b0;
         r_push    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_os_cnt  <= w_os_cnt_n;
         r_bit_idx <= w_bit_idx_n;
         r_hold    <= w_hold_n;
         r_push    <= w_push_n;
         r_ferr    <= w_ferr_n;
      end
   end

`ifdef RX_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         r_par_bad <= w_par_bad_n;
         r_perr    <= w_perr_n;
      end
   end
   assign parity_err = r_perr;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
   end

   assign framing_err = r_ferr;

   // Receive FIFO: r_shift is stable for the clk after the stop sample, so it is written directly.
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_rd, w_wr, r_ovr;

   assign fifo_empty = (r_count == '0);
   assign fifo_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_rd       = CPU_read && !fifo_empty;
   assign w_wr       = r_push && (!fifo_full || w_rd);
   assign data_out   = fifo_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign overrun_err = r_ovr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovr    <= 1'b0;
      end else begin
         r_ovr <= r_push && fifo_full && !w_rd;
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_shift;
   end

endmodule
